// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic array controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sa_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_W = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } sa_state_t;

   // Buffer read latency: data requested at step k reaches the array at k+RD_LAT.
   localparam int RD_LAT = 1;

   // Width of the step counter; it must reach M_max + rows + cols without wrapping.
   function automatic int t_cnt_width(input int cnt_w, input int rows, input int cols);
      return $clog2((1 << cnt_w) + rows + cols);
   endfunction

endpackage

// File: rtl/sa_window_gen.sv
// Per-lane valid-window mask: lane i is high while base+i+RD_LAT <= t <= base+i+M.
// Latency: purely combinational.
// Backpressure: none.
// Ports: t (stream step counter), m (vector count), mask (one bit per lane).
module sa_window_gen
   import sa_pkg::*;
#(
   parameter int N     = 4,
   parameter int BASE  = 0,
   parameter int CNT_W = 8,
   parameter int T_W   = 9
) (
   input  logic [T_W-1:0]   t,
   input  logic [CNT_W-1:0] m,
   output logic [N-1:0]     mask
);

   logic [T_W-1:0] m_ext;

   assign m_ext = T_W'(m);

   // With m == 0 the lower bound exceeds the upper bound, so the lane stays low.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (t >= T_W'(BASE + i + RD_LAT)) &&
                   (t <= T_W'(BASE + i + RD_LAT - 1) + m_ext);
      end
   end

endmodule

// File: rtl/systolic_array_controller.sv
// Sequences a ROWS x COLS weight-stationary systolic array: weight load, skewed input stream, result-valid marks.
// Latency: every output is registered one cycle after the state/counter that produces it.
// Backpressure: none; start is only honoured in IDLE and the job runs at a fixed cadence.
// Ports: start/num_vectors/keep_weights (job command), busy/done (status), w_rd_* (weight buffer),
//        pe_load (PE load strobe), in_rd_* (input buffer), row_en (skewed row valids), col_out_en (column result valids).
module systolic_array_controller
   import sa_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int CNT_W = 8,
   parameter int W_AW  = $clog2(ROWS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             keep_weights,
   output logic             busy,
   output logic             done,
   output logic             w_rd_en,
   output logic [W_AW-1:0]  w_rd_addr,
   output logic             pe_load,
   output logic             in_rd_en,
   output logic [CNT_W-1:0] in_rd_addr,
   output logic [ROWS-1:0]  row_en,
   output logic [COLS-1:0]  col_out_en
);

   localparam int T_W = t_cnt_width(CNT_W, ROWS, COLS);

   sa_state_t        state, state_nxt;
   logic [T_W-1:0]   cnt, cnt_nxt;     // k in LOAD_W, t in STREAM
   logic [CNT_W-1:0] m_q;
   logic [T_W-1:0]   stream_last;
   logic [ROWS-1:0]  row_mask;
   logic [COLS-1:0]  col_mask;

   logic             busy_d, done_d, w_rd_en_d, pe_load_d, in_rd_en_d;
   logic [W_AW-1:0]  w_rd_addr_d;
   logic [CNT_W-1:0] in_rd_addr_d;
   logic [ROWS-1:0]  row_en_d;
   logic [COLS-1:0]  col_out_en_d;

   assign stream_last = T_W'(m_q) + T_W'(ROWS + COLS - 1);

   sa_window_gen #(.N(ROWS), .BASE(0), .CNT_W(CNT_W), .T_W(T_W)) u_row_win (
      .t    (cnt),
      .m    (m_q),
      .mask (row_mask)
   );

   sa_window_gen #(.N(COLS), .BASE(ROWS), .CNT_W(CNT_W), .T_W(T_W)) u_col_win (
      .t    (cnt),
      .m    (m_q),
      .mask (col_mask)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         m_q   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_IDLE && start) begin
            m_q <= num_vectors;
         end
      end
   end

   // Next state. keep_weights only steers the IDLE branch, so it needs no holding register.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (!keep_weights)             state_nxt = S_LOAD_W;
               else if (num_vectors != '0)    state_nxt = S_STREAM;
               else                           state_nxt = S_DONE;
            end
         end
         S_LOAD_W: begin
            if (cnt == T_W'(ROWS)) state_nxt = (m_q != '0) ? S_STREAM : S_DONE;
            else                   cnt_nxt   = cnt + T_W'(1);
         end
         S_STREAM: begin
            if (cnt == stream_last) state_nxt = S_DONE;
            else                    cnt_nxt   = cnt + T_W'(1);
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode. Weights are read bottom row first; pe_load trails the read by RD_LAT.
   always_comb begin
      busy_d       = (state != S_IDLE);
      done_d       = (state == S_DONE);
      w_rd_en_d    = 1'b0;
      w_rd_addr_d  = '0;
      pe_load_d    = 1'b0;
      in_rd_en_d   = 1'b0;
      in_rd_addr_d = '0;
      row_en_d     = '0;
      col_out_en_d = '0;
      case (state)
         S_LOAD_W: begin
            if (cnt < T_W'(ROWS)) begin
               w_rd_en_d   = 1'b1;
               w_rd_addr_d = W_AW'(T_W'(ROWS - 1) - cnt);
            end
            pe_load_d = (cnt >= T_W'(RD_LAT));
         end
         S_STREAM: begin
            if (cnt < T_W'(m_q)) begin
               in_rd_en_d   = 1'b1;
               in_rd_addr_d = cnt[CNT_W-1:0];
            end
            row_en_d     = row_mask;
            col_out_en_d = col_mask;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         w_rd_en    <= 1'b0;
         w_rd_addr  <= '0;
         pe_load    <= 1'b0;
         in_rd_en   <= 1'b0;
         in_rd_addr <= '0;
         row_en     <= '0;
         col_out_en <= '0;
      end else begin
         busy       <= busy_d;
         done       <= done_d;
         w_rd_en    <= w_rd_en_d;
         w_rd_addr  <= w_rd_addr_d;
         pe_load    <= pe_load_d;
         in_rd_en   <= in_rd_en_d;
         in_rd_addr <= in_rd_addr_d;
         row_en     <= row_en_d;
         col_out_en <= col_out_en_d;
      end
   end

endmodule

// File: tb/tb_systolic_array_controller.sv
// Bench for systolic_array_controller: directed corner jobs plus randomized jobs.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_systolic_array_controller;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int CNT_W = 8;
   localparam int W_AW  = 2;

   logic             CLK = 1'b0;
   logic             RST;
   logic             start;
   logic [CNT_W-1:0] num_vectors;
   logic             keep_weights;
   logic             busy, done, w_rd_en, pe_load, in_rd_en;
   logic [W_AW-1:0]  w_rd_addr;
   logic [CNT_W-1:0] in_rd_addr;
   logic [ROWS-1:0]  row_en;
   logic [COLS-1:0]  col_out_en;

   systolic_array_controller #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .W_AW(W_AW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .num_vectors  (num_vectors),
      .keep_weights (keep_weights),
      .busy         (busy),
      .done         (done),
      .w_rd_en      (w_rd_en),
      .w_rd_addr    (w_rd_addr),
      .pe_load      (pe_load),
      .in_rd_en     (in_rd_en),
      .in_rd_addr   (in_rd_addr),
      .row_en       (row_en),
      .col_out_en   (col_out_en)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a job is a timeline of cycles 0..D counted from the start edge.
   // Cycle n shows the outputs of the n-th step; done lands on cycle D.
   bit have = 1'b0;
   bit jk   = 1'b0;
   int cyc  = 0;
   int jm   = 0;
   int jd   = 0;

   function automatic int load_len(input bit k);
      return k ? 0 : ROWS + 1;
   endfunction

   function automatic int stream_len(input int m);
      return (m > 0) ? m + ROWS + COLS : 0;
   endfunction

   initial begin
      forever begin
         @(posedge CLK);
         if (RST) begin
            have = 1'b0;
         end else if (!have || cyc >= jd) begin
            if (start) begin
               have = 1'b1;
               cyc  = 0;
               jm   = int'(num_vectors);
               jk   = keep_weights;
               jd   = load_len(jk) + stream_len(jm) + 1;
            end else begin
               cyc++;
            end
         end else begin
            cyc++;
         end
      end
   end

   bit              chk_on = 1'b0;
   int              e_busy, e_done, e_wen, e_waddr, e_pel, e_ien, e_iaddr, tt;
   logic [ROWS-1:0] e_row;
   logic [COLS-1:0] e_col;

   always @(negedge CLK) begin
      if (chk_on) begin
         e_busy = 0; e_done = 0; e_wen = 0; e_waddr = 0; e_pel = 0;
         e_ien = 0; e_iaddr = 0; e_row = '0; e_col = '0;
         if (have && cyc >= 1 && cyc <= jd) begin
            e_busy = 1;
            e_done = (cyc == jd) ? 1 : 0;
            if (!jk) begin
               e_wen   = (cyc <= ROWS) ? 1 : 0;
               e_waddr = ROWS - cyc;
               e_pel   = (cyc >= 2 && cyc <= ROWS + 1) ? 1 : 0;
            end
            tt = cyc - (load_len(jk) + 1);
            if (tt >= 0 && tt < stream_len(jm)) begin
               e_ien   = (tt < jm) ? 1 : 0;
               e_iaddr = tt;
               for (int r = 0; r < ROWS; r++) e_row[r] = (tt >= r + 1 && tt <= r + jm);
               for (int c = 0; c < COLS; c++) e_col[c] = (tt >= ROWS + c + 1 && tt <= ROWS + c + jm);
            end
         end
         chk("busy",    32'(busy),       e_busy);
         chk("done",    32'(done),       e_done);
         chk("w_rd_en", 32'(w_rd_en),    e_wen);
         chk("pe_load", 32'(pe_load),    e_pel);
         chk("in_rd_en", 32'(in_rd_en),  e_ien);
         chk("row_en",  32'(row_en),     32'(e_row));
         chk("col_en",  32'(col_out_en), 32'(e_col));
         if (e_wen != 0) chk("w_rd_addr",  32'(w_rd_addr),  e_waddr);
         if (e_ien != 0) chk("in_rd_addr", 32'(in_rd_addr), e_iaddr);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_done(input int budget, input bit noisy);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         if (noisy) begin
            start       = 1'($urandom_range(0, 1));
            num_vectors = CNT_W'($urandom);
         end
         tick();
         k++;
      end
      chk("timeout", 32'(done), 32'd1);
      start = 1'b0;
   endtask

   task automatic job(input int m, input bit k, input bit noisy);
      start        = 1'b1;
      num_vectors  = CNT_W'(m);
      keep_weights = k;
      tick();
      start        = 1'b0;
      num_vectors  = CNT_W'($urandom);
      keep_weights = 1'($urandom_range(0, 1));
      wait_done(600, noisy);
   endtask

   initial begin
      RST = 1'b1; start = 1'b0; num_vectors = '0; keep_weights = 1'b0;
      tick(2);
      chk_on = 1'b1;
      RST = 1'b0;
      tick(2);

      // reset while idle
      RST = 1'b1; tick(2); RST = 1'b0; tick();

      job(3, 1'b0, 1'b0);
      job(1, 1'b1, 1'b0);
      job(0, 1'b0, 1'b0);
      job(0, 1'b1, 1'b0);

      // start held high for the whole job, including the DONE cycle
      start = 1'b1; num_vectors = 8'd2; keep_weights = 1'b0;
      wait_done(600, 1'b0);
      tick(3);

      job(255, 1'b1, 1'b0);
      tick(2);

      // reset during STREAM aborts without done, then a fresh job
      start = 1'b1; num_vectors = 8'd20; keep_weights = 1'b1;
      tick(); start = 1'b0;
      tick(6);
      RST = 1'b1; tick(); RST = 1'b0;
      tick(3);
      job(2, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         tick($urandom_range(0, 3));
         job($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
